// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_CNT_EN.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    ENTER  = 2'd2,
    HALTED = 2'd3
  } pc_state_e;

  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int DCNT_W           = 3;   // holds DRAIN_CYCLES-1 for the 1..7 range
  localparam int PERF_W           = 32;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> pipeline controller bundle: hazard/interrupt inputs and stage controls.
interface pipeline_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int INT_NUM = 3
) ();
  localparam int SEL_W = sel_w(INT_NUM);

  logic               go;
  logic               ex_mem_read;
  logic [4:0]         ex_rd;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_uses_rs;
  logic               id_uses_rt;
  logic               ex_branch_taken;
  logic               wb_halt;
  logic               int_en;
  logic [INT_NUM-1:0] int_req;

  logic               pc_en;
  logic               if_id_en;
  logic               id_ex_en;
  logic               ex_dm_en;
  logic               dm_wb_en;
  logic               if_id_stall;
  logic               if_id_clr_n;
  logic               id_ex_clr_n;
  logic               ex_dm_clr_n;
  logic               dm_wb_clr_n;
  logic               int_take;
  logic [SEL_W-1:0]   int_sel;
  logic               halted;
  logic [PERF_W-1:0]  stall_cnt;
  logic [PERF_W-1:0]  flush_cnt;

  modport master (
    output go, ex_mem_read, ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_branch_taken, wb_halt, int_en, int_req,
    input  pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en, if_id_stall,
           if_id_clr_n, id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n,
           int_take, int_sel, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  go, ex_mem_read, ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_branch_taken, wb_halt, int_en, int_req,
    output pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en, if_id_stall,
           if_id_clr_n, id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n,
           int_take, int_sel, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module pipe_hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       hz
);
  assign hz = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register control: load-use stall, branch flush, interrupt drain/entry, halt.
// Define PIPE_CTRL_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INT_NUM      = 3,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  pc
);
  localparam int SEL_W = sel_w(INT_NUM);

  pc_state_e         state_q, state_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d, sel_lo;
  logic              hz, acc;
  logic              pc_en, en, stall, if_clr_n, ex_clr_n, take, halted;

  pipe_hazard_detect u_hz (
    .ex_mem_read (pc.ex_mem_read),
    .ex_rd       (pc.ex_rd),
    .id_rs       (pc.id_rs),
    .id_rt       (pc.id_rt),
    .id_uses_rs  (pc.id_uses_rs),
    .id_uses_rt  (pc.id_uses_rt),
    .hz          (hz)
  );

  assign acc = pc.int_en && (|pc.int_req) && !pc.ex_branch_taken && !hz && !pc.wb_halt;

  // Lowest-index request wins: scan from the top so the last hit is the lowest.
  always_comb begin
    sel_lo = '0;
    for (int i = INT_NUM - 1; i >= 0; i--)
      if (pc.int_req[i]) sel_lo = SEL_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    pc_en    = 1'b1;
    en       = 1'b1;
    stall    = 1'b0;
    if_clr_n = 1'b1;
    ex_clr_n = 1'b1;
    take     = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (pc.wb_halt) begin
          state_d = HALTED;
          pc_en   = 1'b0;
          en      = 1'b0;
        end else if (pc.ex_branch_taken) begin
          if_clr_n = 1'b0;
          ex_clr_n = 1'b0;
        end else if (hz || acc) begin
          pc_en    = 1'b0;
          stall    = 1'b1;
          ex_clr_n = 1'b0;
          if (acc) begin
            sel_d   = sel_lo;
            cnt_d   = DCNT_W'(DRAIN_CYCLES - 1);
            state_d = (DRAIN_CYCLES == 1) ? ENTER : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pc.wb_halt) begin
          // Halt preempts the pending entry; the request is re-evaluated after go.
          state_d = HALTED;
          pc_en   = 1'b0;
          en      = 1'b0;
        end else begin
          pc_en    = 1'b0;
          stall    = 1'b1;
          ex_clr_n = 1'b0;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (cnt_q <= DCNT_W'(1)) state_d = ENTER;
        end
      end
      ENTER: begin
        take     = 1'b1;
        if_clr_n = 1'b0;
        ex_clr_n = 1'b0;
        state_d  = RUN;
      end
      HALTED: begin
        pc_en  = 1'b0;
        en     = 1'b0;
        halted = 1'b1;
        if (pc.go) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign pc.pc_en       = pc_en;
  assign pc.if_id_en    = en;
  assign pc.id_ex_en    = en;
  assign pc.ex_dm_en    = en;
  assign pc.dm_wb_en    = en;
  assign pc.if_id_stall = stall && if_clr_n;
  assign pc.if_id_clr_n = if_clr_n;
  assign pc.id_ex_clr_n = ex_clr_n;
  assign pc.ex_dm_clr_n = 1'b1;
  assign pc.dm_wb_clr_n = 1'b1;
  assign pc.int_take    = take;
  assign pc.int_sel     = sel_q;
  assign pc.halted      = halted;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (state_q != HALTED) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (!if_clr_n && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign pc.stall_cnt = stall_cnt_q;
  assign pc.flush_cnt = flush_cnt_q;
`else
  assign pc.stall_cnt = '0;
  assign pc.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, branch flush, interrupt entry, halt, reset.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  pipeline_ctrl_if #(.INT_NUM(3)) bus ();

  pipeline_ctrl #(.INT_NUM(3), .DRAIN_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .pc  (bus.slave)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id/id_ex/ex_dm/dm_wb en, if_id_stall, if_id/id_ex/ex_dm/dm_wb clr_n, int_take, halted}
  localparam logic [11:0] NORM  = 12'b1_1111_0_1111_0_0;
  localparam logic [11:0] HZ    = 12'b0_1111_1_1011_0_0;
  localparam logic [11:0] BR    = 12'b1_1111_0_0011_0_0;
  localparam logic [11:0] ENT   = 12'b1_1111_0_0011_1_0;
  localparam logic [11:0] FRZ   = 12'b0_0000_0_1111_0_0;
  localparam logic [11:0] HLT   = 12'b0_0000_0_1111_0_1;

  function automatic logic [11:0] ctl();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_dm_en, bus.dm_wb_en,
            bus.if_id_stall, bus.if_id_clr_n, bus.id_ex_clr_n, bus.ex_dm_clr_n,
            bus.dm_wb_clr_n, bus.int_take, bus.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.ex_mem_read     = 1'b0;
    bus.ex_rd           = 5'd0;
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.wb_halt         = 1'b0;
    bus.int_en          = 1'b0;
    bus.int_req         = 3'b000;
  endtask

  task automatic set_hz();
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd8;
    bus.id_rs       = 5'd8;
    bus.id_uses_rs  = 1'b1;
  endtask

  initial begin
    logic take_seen;
    rst    = 1'b1;
    bus.go = 1'b0;
    clr_in();
    #3;
    chk("rst_ctl", 32'(ctl()), 32'(NORM));
    chk("rst_sel", 32'(bus.int_sel), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    cyc(); #1 chk("idle", 32'(ctl()), 32'(NORM));

    cyc(); set_hz(); #1 chk("hz_rs", 32'(ctl()), 32'(HZ));
    cyc(); clr_in(); #1 chk("hz_once", 32'(ctl()), 32'(NORM));
    cyc(); bus.ex_mem_read = 1'b1; bus.id_uses_rs = 1'b1;
    #1 chk("hz_rd0", 32'(ctl()), 32'(NORM));
    cyc(); bus.ex_rd = 5'd5; bus.id_rt = 5'd5; bus.id_uses_rt = 1'b1; bus.id_uses_rs = 1'b0;
    #1 chk("hz_rt", 32'(ctl()), 32'(HZ));
    cyc(); bus.id_uses_rt = 1'b0; #1 chk("hz_unused", 32'(ctl()), 32'(NORM));

    cyc(); clr_in(); set_hz(); bus.ex_branch_taken = 1'b1;
    #1 chk("br_over_hz", 32'(ctl()), 32'(BR));

    // Interrupt entry: accept, two drain cycles, enter, back to run.
    cyc(); clr_in(); bus.int_en = 1'b1; bus.int_req = 3'b110;
    #1 chk("int_acc", 32'(ctl()), 32'(HZ));
    cyc(); bus.int_req = 3'b000; #1 chk("drain1", 32'(ctl()), 32'(HZ));
    cyc(); #1 chk("drain2", 32'(ctl()), 32'(HZ));
    cyc(); #1 chk("enter", 32'(ctl()), 32'(ENT));
    chk("enter_sel", 32'(bus.int_sel), 32'd1);
    cyc(); #1 chk("post_enter", 32'(ctl()), 32'(NORM));

    cyc(); bus.int_en = 1'b0; bus.int_req = 3'b110; #1 chk("int_dis", 32'(ctl()), 32'(NORM));
    cyc(); #1 chk("int_dis2", 32'(ctl()), 32'(NORM));

    // Deferral behind a taken branch.
    cyc(); bus.int_en = 1'b1; bus.int_req = 3'b001; bus.ex_branch_taken = 1'b1;
    #1 chk("defer_br", 32'(ctl()), 32'(BR));
    cyc(); bus.ex_branch_taken = 1'b0; #1 chk("defer_acc", 32'(ctl()), 32'(HZ));
    cyc(); bus.int_req = 3'b000; #1 chk("defer_dr1", 32'(ctl()), 32'(HZ));
    cyc(); #1 chk("defer_dr2", 32'(ctl()), 32'(HZ));
    cyc(); #1 chk("defer_ent", 32'(ctl()), 32'(ENT));
    chk("defer_sel", 32'(bus.int_sel), 32'd0);

    // Halt during drain drops the entry; go re-accepts the held request.
    cyc(); bus.int_req = 3'b100; #1 chk("h_acc", 32'(ctl()), 32'(HZ));
    cyc(); bus.wb_halt = 1'b1; #1 chk("h_drain_halt", 32'(ctl()), 32'(FRZ));
    cyc(); bus.wb_halt = 1'b0; #1 chk("h_halted", 32'(ctl()), 32'(HLT));
    cyc(); #1 chk("h_hold", 32'(ctl()), 32'(HLT));
    cyc(); bus.go = 1'b1; #1 chk("h_go", 32'(ctl()), 32'(HLT));
    cyc(); bus.go = 1'b0; #1 chk("h_reacc", 32'(ctl()), 32'(HZ));
    cyc(); bus.int_req = 3'b000; #1 chk("h_dr1", 32'(ctl()), 32'(HZ));
    cyc(); #1 chk("h_dr2", 32'(ctl()), 32'(HZ));
    cyc(); #1 chk("h_ent", 32'(ctl()), 32'(ENT));
    chk("h_sel", 32'(bus.int_sel), 32'd2);

    // Reset in the middle of a drain.
    cyc(); bus.int_req = 3'b010; #1 chk("r_acc", 32'(ctl()), 32'(HZ));
    cyc(); bus.int_req = 3'b000; #1 chk("r_drain", 32'(ctl()), 32'(HZ));
    #1 rst = 1'b1;
    #1 chk("r_mid_ctl", 32'(ctl()), 32'(NORM));
    chk("r_mid_sel", 32'(bus.int_sel), 32'd0);
    cyc(); rst = 1'b0;
    take_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      take_seen = take_seen | bus.int_take;
    end
    chk("r_no_take", 32'(take_seen), 32'd0);

`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("perf_stall0", bus.stall_cnt, 32'd0);
    chk("perf_flush0", bus.flush_cnt, 32'd0);
    cyc(); set_hz();
    cyc(); clr_in(); #1 chk("perf_stall1", bus.stall_cnt, 32'd1);
    cyc(); bus.ex_branch_taken = 1'b1;
    cyc(); clr_in(); #1 chk("perf_flush1", bus.flush_cnt, 32'd1);
`else
    cyc(); set_hz();
    cyc(); clr_in(); #1 chk("perf_off_stall", bus.stall_cnt, 32'd0);
    chk("perf_off_flush", bus.flush_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Drives the control side of the four pipeline registers (IF/ID, ID/EX, EX/DM, DM/WB) and the PC enable. These registers consume `en`, `stall` and active-low `clr` signals, and this block produces them.
- Detects load-use hazards, flushes on taken branches, and sequences interrupt entry (drain, then flush and redirect).
- Freezes the core on a halt that has reached WB.
- Sits beside the datapath. All hazard inputs come from ID and EX stage register outputs.

Parameters:
- INT_NUM, 3: number of interrupt request lines.
- DRAIN_CYCLES, 3: cycles spent draining EX/DM/WB before interrupt entry; legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- go  in  1  single-cycle pulse that resumes from HALTED
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  source register is actually read
- ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle
- wb_halt  in  1  halt (syscall) instruction is in WB
- int_en  in  1  global interrupt enable from CP0
- int_req  in  INT_NUM  level interrupt requests
- pc_en  out  1  PC register update enable
- if_id_en, id_ex_en, ex_dm_en, dm_wb_en  out  1 each  stage register enables
- if_id_stall  out  1  hold IF/ID
- if_id_clr_n, id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n  out  1 each  synchronous clear, active low
- int_take  out  1  one-cycle pulse; CP0 loads EPC from IF/ID pc and the PC mux selects the vector
- int_sel  out  clog2(INT_NUM)  index of the interrupt being taken
- halted  out  1  core frozen
- stall_cnt, flush_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - State RUN, drain counter 0, int_sel 0.
  - pc_en=1, all stage enables 1, if_id_stall=0, all clr_n=1, int_take=0, halted=0.
- Outputs are decoded from the state plus the RUN-cycle conditions below (Mealy). State, counter and int_sel are registered.
- Load-use hazard (hz) = ex_mem_read && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
- Interrupt acceptance (acc) = int_en && |int_req && !ex_branch_taken && !hz && !wb_halt. int_sel latches the lowest set index of int_req.
- RUN, resolved in priority order:
  1. wb_halt: move to HALTED. This cycle all enables=0 and pc_en=0.
  2. ex_branch_taken: if_id_clr_n=0, id_ex_clr_n=0, pc_en=1. The instruction in ID is wrong-path, so hz is ignored.
  3. hz: pc_en=0, if_id_stall=1, id_ex_clr_n=0 (bubble). Exactly one cycle per hazard occurrence.
  4. acc: same outputs as hz. Move to DRAIN with counter=DRAIN_CYCLES-1; if DRAIN_CYCLES==1, go directly to ENTER.
  5. Otherwise, normal flow with all enables high.
- DRAIN:
  - Outputs: pc_en=0, if_id_stall=1, id_ex_clr_n=0. EX/DM/WB keep advancing.
  - Counter decrements each cycle; when it is 0, go to ENTER.
  - wb_halt in DRAIN goes to HALTED and drops the pending entry. The request is re-accepted after go if still asserted.
  - int_req deasserting during DRAIN does not abort the sequence.
- ENTER (one cycle):
  - int_take=1, if_id_clr_n=0, id_ex_clr_n=0, pc_en=1. Then return to RUN.
  - ex_dm_clr_n and dm_wb_clr_n stay 1; those stages hold only bubbles at this point.
- HALTED:
  - Outputs: pc_en=0, all stage enables=0, halted=1.
  - go goes to RUN; outputs return to normal the cycle after go. go in any other state is ignored.
- IF/ID is never cleared and stalled in the same cycle. Clear wins.
- ex_dm_clr_n and dm_wb_clr_n are always 1 in this revision; they are ported for future exceptions.
- rst asserted in any state returns immediately to the reset values. A partial drain is abandoned.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with pc_en=0 outside HALTED.
  - flush_cnt increments on every cycle with if_id_clr_n=0.
  - Both are 32-bit, saturate at 0xFFFFFFFF and reset to 0.
- Undefined: both ports are driven 0 and no counter flops exist.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding (RUN=2'd0, DRAIN=2'd1, ENTER=2'd2, HALTED=2'd3)
  - DRAIN_CYCLES default
  - counter width constant
- Sub-module pipe_hazard_detect: combinational hz compare, instantiated once.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle -> pc_en=0, if_id_stall=1, id_ex_clr_n=0 that cycle only. With ex_rd=0, no stall.
- Branch over hazard: ex_branch_taken=1 with hz true -> if_id_clr_n=0, id_ex_clr_n=0, pc_en=1, if_id_stall=0.
- Interrupt entry: int_en=1, int_req=3'b110 -> acceptance cycle plus 2 DRAIN cycles with pc_en=0, then int_take=1 with int_sel=1 on cycle 3, RUN on cycle 4. Same request with int_en=0 -> never taken.
- Deferral: int_req asserted while ex_branch_taken=1 -> no acceptance that cycle; acceptance the following cycle.
- Halt: wb_halt=1 during DRAIN -> halted=1, all enables 0, no int_take. go pulse -> RUN, and the still-asserted int_req is re-accepted.
- Reset mid-DRAIN: rst pulse -> all outputs at reset values immediately, int_take never asserted. With PIPE_CTRL_PERF_CNT_EN, stall_cnt=0 after reset and 1 after a single hz cycle.
